// File: rtl/snake_head_ctrl.sv
// Key/frame driven snake head controller: heading, grid stepping, wall death, game FSM.
// Latency: key_ev 3 clk after key_pressed rises; step_pulse/head update 1 clk after frame_ev.
// Backpressure: none; events are consumed on arrival, renderer must accept every step_pulse.
module snake_head_ctrl #(
    parameter int MOVE_DIV = 4,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int START_X  = 32,
    parameter int START_Y  = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_pressed,
    input  logic [7:0] key_code,
    input  logic       vsync,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [1:0] dir,
    output logic       step_pulse,
    output logic       died,
    output logic       running,
    output logic       paused
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    localparam logic [6:0] X_MAX    = 7'(GRID_W - 1);
    localparam logic [5:0] Y_MAX    = 6'(GRID_H - 1);
    localparam logic [6:0] X_START  = 7'(START_X);
    localparam logic [5:0] Y_START  = 6'(START_Y);
    localparam logic [3:0] CNT_LAST = 4'(MOVE_DIV - 1);

    logic [2:0] r_key_s;
    logic [2:0] r_vs_s;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [6:0] r_x;
    logic [5:0] r_y;
    logic [1:0] r_dir;
    logic [1:0] r_pend;
    logic       r_step;
    logic       r_died;

    logic       w_key_ev;
    logic       w_frame_ev;
    logic       w_space;
    logic       w_arrow;
    logic [1:0] w_arrow_dir;
    logic       w_reverse;
    logic       w_wall;
    logic       w_cnt_done;

    assign w_key_ev   = r_key_s[1] & ~r_key_s[2];
    assign w_frame_ev = ~r_vs_s[1] & r_vs_s[2];
    assign w_space    = w_key_ev && (key_code == 8'h29);
    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_reverse  = (w_arrow_dir == {r_dir[1], ~r_dir[0]});

    always_comb begin
        w_arrow     = w_key_ev;
        w_arrow_dir = DIR_RIGHT;
        case (key_code)
            8'h74:   w_arrow_dir = DIR_RIGHT;
            8'h6B:   w_arrow_dir = DIR_LEFT;
            8'h72:   w_arrow_dir = DIR_DOWN;
            8'h75:   w_arrow_dir = DIR_UP;
            default: w_arrow     = 1'b0;
        endcase
    end

    // Wall test on the current cell so the head never takes an out-of-range value.
    always_comb begin
        w_wall = 1'b0;
        case (r_pend)
            DIR_RIGHT: w_wall = (r_x == X_MAX);
            DIR_LEFT:  w_wall = (r_x == 7'd0);
            DIR_DOWN:  w_wall = (r_y == Y_MAX);
            default:   w_wall = (r_y == 6'd0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s <= 3'b000;
            r_vs_s  <= 3'b000;
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_x     <= X_START;
            r_y     <= Y_START;
            r_dir   <= DIR_RIGHT;
            r_pend  <= DIR_RIGHT;
            r_step  <= 1'b0;
            r_died  <= 1'b0;
        end else begin
            r_key_s <= {r_key_s[1:0], key_pressed};
            r_vs_s  <= {r_vs_s[1:0], vsync};
            r_step  <= 1'b0;
            r_died  <= 1'b0;

            // Reversal is judged against the committed heading, not the pending one.
            if (w_arrow && !w_reverse && (r_state != ST_DEAD))
                r_pend <= w_arrow_dir;

            case (r_state)
                ST_IDLE: begin
                    if (w_space || w_arrow) begin
                        r_state <= ST_RUN;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_RUN: begin
                    if (w_space) begin
                        r_state <= ST_PAUSE;
                    end else if (w_frame_ev) begin
                        if (w_cnt_done) begin
                            r_cnt <= 4'd0;
                            if (w_wall) begin
                                r_state <= ST_DEAD;
                                r_died  <= 1'b1;
                            end else begin
                                r_step <= 1'b1;
                                r_dir  <= r_pend;
                                case (r_pend)
                                    DIR_RIGHT: r_x <= r_x + 7'd1;
                                    DIR_LEFT:  r_x <= r_x - 7'd1;
                                    DIR_DOWN:  r_y <= r_y + 6'd1;
                                    default:   r_y <= r_y - 6'd1;
                                endcase
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_space)
                        r_state <= ST_RUN;
                end
                default: begin
                    if (w_space) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                        r_x     <= X_START;
                        r_y     <= Y_START;
                        r_dir   <= DIR_RIGHT;
                        r_pend  <= DIR_RIGHT;
                    end
                end
            endcase
        end
    end

    assign head_x     = r_x;
    assign head_y     = r_y;
    assign dir        = r_dir;
    assign step_pulse = r_step;
    assign died       = r_died;
    assign running    = (r_state == ST_RUN);
    assign paused     = (r_state == ST_PAUSE);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Scoreboard bench for snake_head_ctrl: reference game model predicts steps/deaths,
// a monitor pops predictions whenever the DUT pulses step_pulse or died.
module tb_snake_head_ctrl;

    localparam int MOVE_DIV = 4;
    localparam int GRID_W   = 64;
    localparam int GRID_H   = 48;
    localparam int SX       = 32;
    localparam int SY       = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_pressed = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       vsync = 1'b1;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [1:0] dir;
    logic       step_pulse;
    logic       died;
    logic       running;
    logic       paused;

    snake_head_ctrl #(
        .MOVE_DIV(MOVE_DIV), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .key_code(key_code),
        .vsync(vsync), .head_x(head_x), .head_y(head_y), .dir(dir),
        .step_pulse(step_pulse), .died(died), .running(running), .paused(paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_died;
        int x;
        int y;
        int d;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference game state: 0 idle, 1 run, 2 pause, 3 dead
    int m_state, m_x, m_y, m_dir, m_pend, m_frames;
    int dx[4]  = '{1, -1, 0, 0};
    int dy[4]  = '{0, 0, 1, -1};
    int opp[4] = '{1, 0, 3, 2};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_state = 0; m_x = SX; m_y = SY; m_dir = 0; m_pend = 0; m_frames = 0;
    endfunction

    function automatic int arrow_of(input logic [7:0] c);
        case (c)
            8'h74: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h75: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic void model_key(input logic [7:0] c);
        int a;
        a = arrow_of(c);
        if (c == 8'h29) begin
            case (m_state)
                0: begin m_state = 1; m_frames = 0; end
                1: m_state = 2;
                2: m_state = 1;
                default: model_reset();
            endcase
        end else if (a >= 0 && m_state != 3) begin
            if (a != opp[m_dir]) m_pend = a;
            if (m_state == 0) begin m_state = 1; m_frames = 0; end
        end
    endfunction

    function automatic void model_frame();
        int nx, ny;
        exp_t e;
        if (m_state != 1) return;
        m_frames++;
        if (m_frames < MOVE_DIV) return;
        m_frames = 0;
        nx = m_x + dx[m_pend];
        ny = m_y + dy[m_pend];
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            m_state = 3;
            e = '{1'b1, m_x, m_y, m_dir};
        end else begin
            m_x = nx; m_y = ny; m_dir = m_pend;
            e = '{1'b0, m_x, m_y, m_dir};
        end
        q.push_back(e);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_head_x"}, int'(head_x), m_x);
        check({tag, "_head_y"}, int'(head_y), m_y);
        check({tag, "_dir"}, int'(dir), m_dir);
        check({tag, "_running"}, int'(running), int'(m_state == 1));
        check({tag, "_paused"}, int'(paused), int'(m_state == 2));
    endtask

    task automatic press(input logic [7:0] c);
        model_key(c);
        @(negedge clk);
        key_code = c;
        key_pressed = 1'b1;
        repeat (4) @(negedge clk);
        key_pressed = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("key");
    endtask

    task automatic frame();
        model_frame();
        @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs("frame");
    endtask

    // Monitor: every DUT pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && (step_pulse || died)) begin
            check("pulse_exclusive", int'(step_pulse & died), 0);
            if (q.size() == 0) begin
                check("unexpected_pulse", int'(step_pulse) + 2 * int'(died), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_died) begin
                    check("died_pulse", int'(died), 1);
                    check("died_x", int'(head_x), e.x);
                    check("died_y", int'(head_y), e.y);
                end else begin
                    check("step_pulse", int'(step_pulse), 1);
                    check("step_x", int'(head_x), e.x);
                    check("step_y", int'(head_y), e.y);
                    check("step_dir", int'(dir), e.d);
                end
            end
        end
    end

    logic [7:0] arrows[4] = '{8'h74, 8'h6B, 8'h72, 8'h75};

    initial begin
        int guard;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_step", int'(step_pulse), 0);
        check("reset_died", int'(died), 0);
        check_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Idle: frames do nothing
        repeat (20) frame();
        check("idle_head_x", int'(head_x), 32);

        // Start and run two steps right
        press(8'h29);
        repeat (8) frame();
        check("run_two_steps_x", int'(head_x), 34);

        // Reversal rejected, up accepted
        press(8'h6B);
        press(8'h75);
        repeat (MOVE_DIV) frame();
        check("turn_up_y", int'(head_y), 23);
        check("turn_up_dir", int'(dir), 3);

        // Run right into the wall
        press(8'h74);
        guard = 0;
        while (m_state != 3 && guard < 400) begin
            frame();
            guard++;
        end
        check("wall_reached_dead", m_state, 3);
        check("wall_head_x", int'(head_x), 63);
        repeat (8) frame();

        // Back to idle, then pause mid-count
        press(8'h29);
        check("dead_to_idle_x", int'(head_x), 32);
        press(8'h29);
        repeat (2) frame();
        press(8'h29);
        repeat (10) frame();
        press(8'h72);
        press(8'h29);
        repeat (2) frame();
        check("pause_resume_y", int'(head_y), 25);

        // Reset between the completing frame event and its step
        repeat (MOVE_DIV - 1) frame();
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_step", int'(step_pulse), 0);
        check("rst_mid_died", int'(died), 0);
        check_outputs("rst_mid");
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_outputs("post_rst");

        // Randomized play
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) frame();
            else if (r < 85) press(arrows[$urandom_range(0, 3)]);
            else if (r < 95) press(8'h29);
            else press(8'($urandom_range(0, 255)));
        end

        repeat (6) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
